pc_ras_unit: RTL and testbench
==============================

// Module: pc_ras_unit
// PURPOSE
//  Parametrised program-counter unit for the single-cycle CPU, successor to the basic PC register.
//  Adds call/return via a hardware return-address stack (RAS), register-indirect jump, trap redirect,
//  and misalignment detection. Drives the instruction-memory address; sits between control unit and IM.
// PARAMETERS
//  ADDR_W      32            PC width in bits (>=16)
//  IMM_W       16            branch immediate width (signed, word offset)
//  RAS_DEPTH   4             return-address stack entries (power of 2, >=2)
//  RESET_ADDR  0             PC value after reset
//  TRAP_ADDR   'h80          redirect target on RAS underflow / misaligned indirect jump
// PORTS
//  CLK          in   1         clock, all state updates on rising edge
//  Reset        in   1         synchronous, active-high reset
//  PCWre        in   1         1 = commit nextPC this cycle; 0 = stall (hold all state)
//  PCSrc        in   3         next-PC mode (see BEHAVIOUR)
//  Immediate    in   IMM_W     signed branch word offset
//  JumpIndex    in   ADDR_W-6  pseudo-direct jump index
//  RegTarget    in   ADDR_W    register jump target
//  Address      out  ADDR_W    current PC (registered)
//  nextPC       out  ADDR_W    combinational PC that commits on next edge if PCWre=1
//  PC4          out  4         Address[ADDR_W-1:ADDR_W-4]
//  ras_empty    out  1         RAS count == 0
//  ras_full     out  1         RAS count == RAS_DEPTH
//  ras_ovf      out  1         sticky: push performed while full
//  ras_unf      out  1         sticky: pop attempted while empty
//  trap_taken   out  1         registered, 1 for the cycle after a trap redirect commits
// BEHAVIOUR
//  seq = Address+4; all arithmetic modulo 2^ADDR_W.
//  PCSrc: 000 seq | 001 branch: seq + (sext(Immediate)<<2) | 010 jump: {seq[ADDR_W-1:ADDR_W-4],JumpIndex,2'b00}
//         011 jr: RegTarget | 100 call: jump target, push seq | 101 ret: pop, target = popped entry
//         110 trap: TRAP_ADDR | 111 reserved: treated as seq.
//  jr with RegTarget[1:0]!=0 -> nextPC=TRAP_ADDR (misaligned trap).
//  ret with RAS empty -> nextPC=TRAP_ADDR, ras_unf sets, stack unchanged.
//  RAS: circular buffer, top pointer + count (0..RAS_DEPTH). Push while full overwrites oldest entry,
//   pointer advances, count stays RAS_DEPTH, ras_ovf sets. Pop decrements count, pointer retreats.
//  Stack and flags change only on edges with PCWre=1; PCWre=0 holds Address, RAS, stickies; trap_taken->0.
//  trap_taken<=1 on committed edge whose nextPC source was trap/misaligned/underflow, else 0.
//  Reset (sync, priority over PCWre): Address=RESET_ADDR, count=0, ptr=0, ras_ovf=ras_unf=trap_taken=0;
//   RAS entry contents don't-care. Reset asserted mid-call sequence discards all pending stack state.
//  Latency: nextPC combinational from inputs+state; Address updates one edge later; no bubble.
// TESTING
//  Reset=1 one edge -> Address=0, ras_empty=1, flags 0; then 3 edges PCSrc=000 -> Address 4,8,12.
//  Address=0x10, PCSrc=001, Immediate=-2 (0xFFFE) -> Address=0x0C; Immediate=3 -> 0x20.
//  Address=0x100, PCSrc=100, JumpIndex=0x40 -> Address=0x100, RAS top=0x104; later PCSrc=101 -> 0x104, ras_empty=1.
//  Five calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; four rets return the 4 newest return addresses, 5th -> 0x80, ras_unf=1, trap_taken=1.
//  PCSrc=011, RegTarget=0x202 -> Address=0x80, trap_taken=1; RegTarget=0x200 -> Address=0x200, trap_taken=0.
//  PCWre=0 with PCSrc=100 for 3 edges -> Address and RAS count unchanged; Reset during stall -> RESET_ADDR.

Source files
------------

// File: rtl/pc_ras_unit.sv
// Program-counter unit with a circular return-address stack, register-indirect jump,
// trap redirect and misaligned-target detection. Address is registered; nextPC is combinational.
module pc_ras_unit #(
    parameter int                  ADDR_W     = 32,
    parameter int                  IMM_W      = 16,
    parameter int                  RAS_DEPTH  = 4,
    parameter logic [ADDR_W-1:0]   RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0]   TRAP_ADDR  = 'h80
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWre,
    input  logic [2:0]        PCSrc,
    input  logic [IMM_W-1:0]  Immediate,
    input  logic [ADDR_W-7:0] JumpIndex,
    input  logic [ADDR_W-1:0] RegTarget,
    output logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] nextPC,
    output logic [3:0]        PC4,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf,
    output logic              trap_taken
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] SRC_SEQ    = 3'b000;
    localparam logic [2:0] SRC_BRANCH = 3'b001;
    localparam logic [2:0] SRC_JUMP   = 3'b010;
    localparam logic [2:0] SRC_JR     = 3'b011;
    localparam logic [2:0] SRC_CALL   = 3'b100;
    localparam logic [2:0] SRC_RET    = 3'b101;
    localparam logic [2:0] SRC_TRAP   = 3'b110;

    logic [ADDR_W-1:0] address_q, address_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q, unf_q, trap_q;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] jump_tgt;
    logic [PTR_W-1:0]  pop_idx;
    logic              push, pop, underflow, trap_src;

    // ptr_q names the next free slot; when full that slot holds the oldest entry.
    assign pop_idx   = ptr_q - PTR_W'(1);
    assign seq_addr  = address_q + ADDR_W'(4);
    assign imm_ext   = ADDR_W'($signed(Immediate));
    assign jump_tgt  = {seq_addr[ADDR_W-1 -: 4], JumpIndex, 2'b00};
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        address_d = seq_addr;
        push      = 1'b0;
        pop       = 1'b0;
        underflow = 1'b0;
        trap_src  = 1'b0;
        case (PCSrc)
            SRC_SEQ:    address_d = seq_addr;
            SRC_BRANCH: address_d = seq_addr + (imm_ext << 2);
            SRC_JUMP:   address_d = jump_tgt;
            SRC_JR: begin
                if (RegTarget[1:0] != 2'b00) begin
                    address_d = TRAP_ADDR;
                    trap_src  = 1'b1;
                end else begin
                    address_d = RegTarget;
                end
            end
            SRC_CALL: begin
                address_d = jump_tgt;
                push      = 1'b1;
            end
            SRC_RET: begin
                if (ras_empty) begin
                    address_d = TRAP_ADDR;
                    underflow = 1'b1;
                    trap_src  = 1'b1;
                end else begin
                    address_d = ras_q[pop_idx];
                    pop       = 1'b1;
                end
            end
            SRC_TRAP: begin
                address_d = TRAP_ADDR;
                trap_src  = 1'b1;
            end
            default:    address_d = seq_addr;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            address_q <= RESET_ADDR;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            trap_q    <= 1'b0;
        end else if (PCWre) begin
            address_q <= address_d;
            trap_q    <= trap_src;
            if (push) begin
                ptr_q <= ptr_q + PTR_W'(1);
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                ptr_q <= pop_idx;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (underflow) begin
                unf_q <= 1'b1;
            end
        end else begin
            trap_q <= 1'b0;
        end
    end

    // Entry contents need no reset: count and pointer alone define what is valid.
    always_ff @(posedge CLK) begin
        if (!Reset && PCWre && push) begin
            ras_q[ptr_q] <= seq_addr;
        end
    end

    assign Address    = address_q;
    assign nextPC     = address_d;
    assign PC4        = address_q[ADDR_W-1 -: 4];
    assign ras_ovf    = ovf_q;
    assign ras_unf    = unf_q;
    assign trap_taken = trap_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed vector table, hand-written stall/reset sequence,
// and randomized traffic checked against a queue-based model of the PC and return stack.
module tb_pc_ras_unit;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  src;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] rtgt;
    logic [31:0] addr, npc;
    logic [3:0]  pc4;
    logic        empty, full, ovf, unf, trap;

    int checks = 0;
    int errors = 0;

    pc_ras_unit dut (
        .CLK(clk), .Reset(rst), .PCWre(we), .PCSrc(src), .Immediate(imm),
        .JumpIndex(jidx), .RegTarget(rtgt), .Address(addr), .nextPC(npc),
        .PC4(pc4), .ras_empty(empty), .ras_full(full), .ras_ovf(ovf),
        .ras_unf(unf), .trap_taken(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  src;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] rtgt;
        logic [31:0] e_addr;
        logic        e_empty, e_full, e_ovf, e_unf, e_trap;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic w, logic [2:0] s, logic [15:0] i, logic [25:0] j,
                                logic [31:0] t, logic [31:0] a, logic e, logic f, logic o,
                                logic u, logic tr);
        vec_t v;
        v.rst = r; v.we = w; v.src = s; v.imm = i; v.jidx = j; v.rtgt = t;
        v.e_addr = a; v.e_empty = e; v.e_full = f; v.e_ovf = o; v.e_unf = u; v.e_trap = tr;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic w, logic [2:0] s, logic [15:0] i, logic [25:0] j,
                         logic [31:0] t);
        @(negedge clk);
        rst = r; we = w; src = s; imm = i; jidx = j; rtgt = t;
        #1;
    endtask

    task automatic check_state(string tag, logic [31:0] a, logic e, logic f, logic o,
                               logic u, logic tr);
        check({tag, " addr"}, 64'(addr), 64'(a));
        check({tag, " flags"}, {59'd0, empty, full, ovf, unf, trap}, {59'd0, e, f, o, u, tr});
    endtask

    // Reference model: the return stack is a plain queue, newest at the back.
    logic [31:0] m_addr;
    logic [31:0] m_stk[$];
    logic        m_ovf, m_unf, m_trap;

    function automatic logic [31:0] m_next(output logic is_trap);
        logic [31:0] seq;
        logic [31:0] off;
        seq     = m_addr + 32'd4;
        off     = 32'($signed(imm)) * 32'd4;
        is_trap = 1'b0;
        case (src)
            3'd1: return seq + off;
            3'd2: return (seq & 32'hF000_0000) | ({6'd0, jidx} << 2);
            3'd3: begin
                if (rtgt % 4 != 0) begin is_trap = 1'b1; return 32'h80; end
                return rtgt;
            end
            3'd4: return (seq & 32'hF000_0000) | ({6'd0, jidx} << 2);
            3'd5: begin
                if (m_stk.size() == 0) begin is_trap = 1'b1; return 32'h80; end
                return m_stk[m_stk.size()-1];
            end
            3'd6: begin is_trap = 1'b1; return 32'h80; end
            default: return seq;
        endcase
    endfunction

    task automatic m_commit(logic [31:0] nxt, logic is_trap);
        logic [31:0] tmp;
        if (rst) begin
            m_addr = 32'd0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_trap = 0;
        end else if (we) begin
            if (src == 3'd4) begin
                if (m_stk.size() == 4) begin
                    tmp = m_stk.pop_front();
                    m_ovf = 1'b1;
                end
                m_stk.push_back(m_addr + 32'd4);
            end else if (src == 3'd5) begin
                if (m_stk.size() == 0) m_unf = 1'b1;
                else tmp = m_stk.pop_back();
            end
            m_trap = is_trap;
            m_addr = nxt;
        end else begin
            m_trap = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] exp_npc;
        logic        exp_trap;

        rst = 1; we = 1; src = 0; imm = 0; jidx = 0; rtgt = 0;

        //            rst we src imm       jidx      rtgt       addr        E F O U T
        vecs.push_back(mk(1, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'h0,      1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'h4,      1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'h8,      1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'hC,      1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'h10,     1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd1, 16'hFFFE, 26'h0,   32'h0,   32'hC,      1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd0, 16'h0,    26'h0,   32'h0,   32'h10,     1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd1, 16'h3,    26'h0,   32'h0,   32'h20,     1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd3, 16'h0,    26'h0,   32'h100, 32'h100,    1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h40,  32'h0,   32'h100,    0,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'h104,    1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd3, 16'h0,    26'h0,   32'h202, 32'h80,     1,0,0,0,1));
        vecs.push_back(mk(0, 1, 3'd3, 16'h0,    26'h0,   32'h200, 32'h200,    1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd6, 16'h0,    26'h0,   32'h0,   32'h80,     1,0,0,0,1));
        vecs.push_back(mk(0, 1, 3'd7, 16'h0,    26'h0,   32'h0,   32'h84,     1,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd2, 16'h0,    26'h123, 32'h0,   32'h48C,    1,0,0,0,0));
        // Five calls into a four-deep stack, then five returns.
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h100, 32'h0,   32'h400,    0,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h200, 32'h0,   32'h800,    0,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h300, 32'h0,   32'hC00,    0,0,0,0,0));
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h400, 32'h0,   32'h1000,   0,1,0,0,0));
        vecs.push_back(mk(0, 1, 3'd4, 16'h0,    26'h500, 32'h0,   32'h1400,   0,1,1,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'h1004,   0,0,1,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'hC04,    0,0,1,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'h804,    0,0,1,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'h404,    1,0,1,0,0));
        vecs.push_back(mk(0, 1, 3'd5, 16'h0,    26'h0,   32'h0,   32'h80,     1,0,1,1,1));
        // Stall with a call pending: nothing moves, trap_taken drops.
        vecs.push_back(mk(0, 0, 3'd4, 16'h0,    26'h10,  32'h0,   32'h80,     1,0,1,1,0));
        vecs.push_back(mk(0, 0, 3'd4, 16'h0,    26'h10,  32'h0,   32'h80,     1,0,1,1,0));
        vecs.push_back(mk(0, 0, 3'd4, 16'h0,    26'h10,  32'h0,   32'h80,     1,0,1,1,0));
        vecs.push_back(mk(1, 0, 3'd4, 16'h0,    26'h10,  32'h0,   32'h0,      1,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].src, vecs[i].imm, vecs[i].jidx, vecs[i].rtgt);
            if (vecs[i].we && !vecs[i].rst)
                check($sformatf("vec%0d nextPC", i), 64'(npc), 64'(vecs[i].e_addr));
            @(posedge clk); #1;
            check_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_empty, vecs[i].e_full,
                        vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_trap);
        end

        // Stall must not push: one call, three stalled calls, then three more calls fill exactly.
        drive(1, 1, 3'd0, 0, 0, 0); @(posedge clk); #1;
        drive(0, 1, 3'd4, 0, 26'h10, 0); @(posedge clk); #1;
        check_state("call1", 32'h40, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 3'd4, 0, 26'h20, 0); @(posedge clk); #1;
        end
        check_state("stall3", 32'h40, 0, 0, 0, 0, 0);
        drive(0, 1, 3'd4, 0, 26'h20, 0); @(posedge clk); #1;
        drive(0, 1, 3'd4, 0, 26'h30, 0); @(posedge clk); #1;
        check_state("call3", 32'hC0, 0, 0, 0, 0, 0);
        drive(0, 1, 3'd4, 0, 26'h40, 0); @(posedge clk); #1;
        check_state("call4", 32'h100, 0, 1, 0, 0, 0);
        drive(0, 1, 3'd5, 0, 0, 0); @(posedge clk); #1;
        check_state("ret_after_stall", 32'hC4, 0, 0, 0, 0, 0);
        drive(1, 0, 3'd5, 0, 0, 0); @(posedge clk); #1;
        check_state("reset_in_stall", 32'h0, 1, 0, 0, 0, 0);

        // Randomized traffic against the queue model.
        drive(1, 1, 3'd0, 0, 0, 0);
        m_commit(32'd0, 1'b0);
        @(posedge clk); #1;
        for (int n = 0; n < 3000; n++) begin
            logic r, w;
            logic [2:0] s;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            w = ($urandom_range(0, 99) < 85);
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) s = 3'd4;
            if ($urandom_range(0, 3) == 0) s = 3'd5;
            t = $urandom;
            if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
            drive(r, w, s, 16'($urandom), 26'($urandom), t);
            exp_npc = m_next(exp_trap);
            check("rand nextPC", 64'(npc), 64'(exp_npc));
            m_commit(exp_npc, exp_trap);
            @(posedge clk); #1;
            check("rand addr", 64'(addr), 64'(m_addr));
            check("rand pc4", 64'(pc4), 64'(m_addr[31:28]));
            check("rand flags", {59'd0, empty, full, ovf, unf, trap},
                  {59'd0, m_stk.size() == 0, m_stk.size() == 4, m_ovf, m_unf, m_trap});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
